// File: rtl/window_load_ctrl_if.sv
// Bundle of pixel-memory read, window-buffer strobe and window handshake signals.
interface window_load_ctrl_if #(
  parameter int ADDR_W = 16
);
  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_valid;
  logic [3:0]        num_pix_to_load;
  logic [3:0]        count;
  logic              gray_ready;
  logic              gray_ready2;
  logic              win_valid;
  logic              win_ready;
  logic [ADDR_W-1:0] win_x;
  logic [ADDR_W-1:0] win_y;

  modport master (
    output rd_req, rd_addr, num_pix_to_load, count, gray_ready, gray_ready2,
    output win_valid, win_x, win_y,
    input  rd_valid, win_ready
  );

  modport slave (
    input  rd_req, rd_addr, num_pix_to_load, count, gray_ready, gray_ready2,
    input  win_valid, win_x, win_y,
    output rd_valid, win_ready
  );
endinterface

// File: rtl/window_load_ctrl.sv
// Window load controller: walks a 3x3 window across the frame, fetching one
// pixel at a time and steering each returned pixel into the window buffer.
//
// state  | meaning
// S_IDLE | waiting for start
// S_REQ  | one-cycle read request for pixel k of the current load
// S_WAIT | waiting for the pixel; strobe the buffer in the rd_valid cycle
// S_EMIT | window complete, held until downstream accepts
// S_DONE | one-cycle done pulse after the last window
module window_load_ctrl #(
  parameter int IMG_W  = 8,
  parameter int IMG_H  = 6,
  parameter int ADDR_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_start,
  output logic               o_busy,
  output logic               o_done,
  window_load_ctrl_if.master bus
);

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_EMIT, S_DONE} state_t;

  localparam logic [ADDR_W-1:0] LP_W      = ADDR_W'(IMG_W);
  localparam logic [ADDR_W-1:0] LP_X_LAST = ADDR_W'(IMG_W - 3);
  localparam logic [ADDR_W-1:0] LP_Y_LAST = ADDR_W'(IMG_H - 3);

  state_t            r_state;
  state_t            w_next;
  logic              r_full;
  logic [ADDR_W-1:0] r_x;
  logic [ADDR_W-1:0] r_y;
  logic [ADDR_W-1:0] r_addr;
  logic [3:0]        r_k;

  logic [3:0]        w_kidx;
  logic [1:0]        w_row;
  logic [1:0]        w_col;
  logic [ADDR_W-1:0] w_addr;
  logic              w_last;

  // Slot position of pixel k: column-major for a full load, new right column for a shift.
  always_comb begin
    w_kidx = r_k - 4'd1;
    w_row  = 2'(w_kidx % 4'd3);
    w_col  = 2'd2;
    if (r_full) begin
      w_col = 2'(w_kidx / 4'd3);
    end else begin
      w_row = w_kidx[1:0];
    end
    w_addr = (r_y + ADDR_W'(w_row)) * LP_W + r_x + ADDR_W'(w_col);
    w_last = r_full ? (r_k == 4'd9) : (r_k == 4'd3);
  end

  assign bus.win_x = r_x;
  assign bus.win_y = r_y;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state and output decode; buffer strobes only in the WAIT/rd_valid cycle.
  always_comb begin
    w_next              = r_state;
    bus.rd_req          = 1'b0;
    bus.rd_addr         = r_addr;
    bus.num_pix_to_load = 4'd0;
    bus.count           = 4'd0;
    bus.gray_ready      = 1'b0;
    bus.gray_ready2     = 1'b0;
    bus.win_valid       = 1'b0;
    o_busy              = 1'b1;
    o_done              = 1'b0;
    case (r_state)
      S_IDLE: begin
        o_busy = 1'b0;
        if (i_start) w_next = S_REQ;
      end
      S_REQ: begin
        bus.rd_req  = 1'b1;
        bus.rd_addr = w_addr;
        w_next      = S_WAIT;
      end
      S_WAIT: begin
        if (bus.rd_valid) begin
          bus.num_pix_to_load = r_full ? 4'd9 : 4'd3;
          bus.count           = r_k;
          bus.gray_ready      = r_full;
          bus.gray_ready2     = ~r_full;
          w_next              = w_last ? S_EMIT : S_REQ;
        end
      end
      S_EMIT: begin
        bus.win_valid = 1'b1;
        if (bus.win_ready) begin
          w_next = (r_x == LP_X_LAST && r_y == LP_Y_LAST) ? S_DONE : S_REQ;
        end
      end
      S_DONE: begin
        o_busy = 1'b0;
        o_done = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Window position, load mode, pixel index and held read address.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_full <= 1'b1;
      r_x    <= '0;
      r_y    <= '0;
      r_k    <= 4'd0;
      r_addr <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_full <= 1'b1;
            r_x    <= '0;
            r_y    <= '0;
            r_k    <= 4'd1;
          end
        end
        S_REQ: r_addr <= w_addr;
        S_WAIT: begin
          if (bus.rd_valid && !w_last) r_k <= r_k + 4'd1;
        end
        S_EMIT: begin
          if (bus.win_ready) begin
            if (r_x != LP_X_LAST) begin
              r_x    <= r_x + 1'b1;
              r_full <= 1'b0;
              r_k    <= 4'd1;
            end else if (r_y != LP_Y_LAST) begin
              r_x    <= '0;
              r_y    <= r_y + 1'b1;
              r_full <= 1'b1;
              r_k    <= 4'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_window_load_ctrl.sv
// Bench for window_load_ctrl: memory responder, window buffer model and a
// frame-level reference of the expected read/strobe/window sequence.
module tb_window_load_ctrl;
  localparam int W    = 5;
  localparam int H    = 4;
  localparam int AW   = 16;
  localparam int NWIN = (W - 2) * (H - 2);

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic busy, done;
  logic mem_valid = 1'b0, stray_valid = 1'b0, win_ready_d = 1'b0;
  logic [7:0] mem_pix = '0, stray_pix = '0, pix;

  window_load_ctrl_if #(.ADDR_W(AW)) bus ();
  assign bus.rd_valid  = mem_valid | stray_valid;
  assign bus.win_ready = win_ready_d;
  assign pix = stray_valid ? stray_pix : mem_pix;

  window_load_ctrl #(.IMG_W(W), .IMG_H(H), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .i_start(start), .o_busy(busy), .o_done(done), .bus(bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  logic [7:0] mem [W*H];
  int exp_addr[$], exp_num[$], exp_cnt[$], exp_wx[$], exp_wy[$];

  // Expected sequence from the frame walk: full load at column 0, right-column shift otherwise.
  task automatic build_frame();
    exp_addr.delete(); exp_num.delete(); exp_cnt.delete(); exp_wx.delete(); exp_wy.delete();
    for (int y = 0; y <= H - 3; y++) begin
      for (int x = 0; x <= W - 3; x++) begin
        if (x == 0) begin
          for (int c = 0; c < 3; c++)
            for (int r = 0; r < 3; r++) begin
              exp_addr.push_back((y + r) * W + c);
              exp_num.push_back(9);
              exp_cnt.push_back(c * 3 + r + 1);
            end
        end else begin
          for (int r = 0; r < 3; r++) begin
            exp_addr.push_back((y + r) * W + x + 2);
            exp_num.push_back(3);
            exp_cnt.push_back(r + 1);
          end
        end
        exp_wx.push_back(x);
        exp_wy.push_back(y);
      end
    end
  endtask

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory responder: one read outstanding, latency fixed at 1 or random 1..4.
  logic mem_en = 1'b1;
  logic fixed_lat = 1'b1;
  initial begin
    int a, lat;
    forever begin
      @(posedge clk);
      if (mem_en && !rst && bus.rd_req) begin
        a   = int'(bus.rd_addr);
        lat = fixed_lat ? 1 : int'($urandom_range(1, 4));
        repeat (lat - 1) @(posedge clk);
        #1;
        mem_valid = 1'b1;
        mem_pix   = mem[a % (W * H)];
        @(posedge clk);
        #1 mem_valid = 1'b0;
      end
    end
  end

  // Monitor: checks reads, strobes and accepted windows; models the 3x3 buffer.
  logic mon_en = 1'b0;
  logic [7:0] bufm [9];
  int win_cnt, done_cnt, first_req_cyc, first_addr, nbad, k, ea;
  int win_cyc[$];
  logic prev_wv = 1'b0;
  logic strobe;
  always @(negedge clk) begin
    if (mon_en && !rst) begin
      strobe = bus.gray_ready | bus.gray_ready2 | (bus.num_pix_to_load != 0) | (bus.count != 0);
      if (bus.rd_req) begin
        chk("req_in_emit", bus.win_valid, 0);
        if (first_req_cyc < 0) begin
          first_req_cyc = cyc;
          first_addr = int'(bus.rd_addr);
        end
        chk("req_expected", exp_addr.size() > 0, 1);
        if (exp_addr.size() > 0) chk("rd_addr", bus.rd_addr, exp_addr.pop_front());
      end
      if (strobe) begin
        chk("strobe_rdv", bus.rd_valid, 1);
        chk("strobe_expected", exp_num.size() > 0, 1);
        if (exp_num.size() > 0) begin
          ea = exp_num.pop_front();
          chk("num_pix", bus.num_pix_to_load, ea);
          chk("count", bus.count, exp_cnt.pop_front());
          chk("gray_ready", bus.gray_ready, ea == 9);
          chk("gray_ready2", bus.gray_ready2, ea == 3);
        end
        k = int'(bus.count);
        if (bus.gray_ready && bus.num_pix_to_load == 9 && k >= 1 && k <= 9)
          bufm[((k - 1) % 3) * 3 + (k - 1) / 3] = pix;
        if (bus.gray_ready2 && bus.num_pix_to_load == 3 && k >= 1 && k <= 3) begin
          if (k == 1)
            for (int r = 0; r < 3; r++) begin
              bufm[r * 3]     = bufm[r * 3 + 1];
              bufm[r * 3 + 1] = bufm[r * 3 + 2];
            end
          bufm[(k - 1) * 3 + 2] = pix;
        end
      end
      if (bus.win_valid) chk("strobe_in_emit", strobe, 0);
      if (bus.win_valid && !prev_wv) win_cyc.push_back(cyc);
      if (bus.win_valid && bus.win_ready) begin
        chk("win_expected", exp_wx.size() > 0, 1);
        if (exp_wx.size() > 0) begin
          ea = exp_wx.pop_front();
          chk("win_x", bus.win_x, ea);
          k = exp_wy.pop_front();
          chk("win_y", bus.win_y, k);
          nbad = 0;
          for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
              if (bufm[r * 3 + c] !== mem[(k + r) * W + ea + c]) nbad++;
          chk("win_pixels", nbad, 0);
        end
        win_cnt++;
      end
      if (done) begin
        done_cnt++;
        chk("busy_at_done", busy, 0);
      end
      prev_wv = bus.win_valid;
    end
  end

  task automatic new_frame(input logic lat1);
    fixed_lat = lat1;
    win_cnt = 0; done_cnt = 0; first_req_cyc = -1; first_addr = -1;
    win_cyc.delete();
    build_frame();
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (done_cnt == 0 && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic frame_checks(input string tag);
    repeat (3) @(posedge clk);
    #1;
    chk({tag, "_windows"}, win_cnt, NWIN);
    chk({tag, "_done_pulses"}, done_cnt, 1);
    chk({tag, "_reads_left"}, exp_addr.size(), 0);
    chk({tag, "_busy_after"}, busy, 0);
  endtask

  initial begin
    int iter;
    logic hold_first;
    logic [AW-1:0] wx0, wy0;
    for (int i = 0; i < W * H; i++) mem[i] = 8'($urandom);

    // Reset state
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_rd_req", bus.rd_req, 0);
    chk("rst_win_valid", bus.win_valid, 0);
    chk("rst_count", bus.count, 0);
    chk("rst_num", bus.num_pix_to_load, 0);
    rst = 1'b0;

    // Frame with latency 1 and downstream always ready
    new_frame(1'b1);
    mon_en = 1'b1;
    win_ready_d = 1'b1;
    pulse_start();
    wait_done(3000);
    chk("a_first_addr", first_addr, 0);
    chk("a_full_latency", win_cyc.size() > 0 ? win_cyc[0] - first_req_cyc : -1, 18);
    chk("a_shift_latency", win_cyc.size() > 1 ? win_cyc[1] - win_cyc[0] : -1, 7);
    frame_checks("a");

    // Frame with random latency, back-pressure and a start pulse while busy
    new_frame(1'b0);
    win_ready_d = 1'b0;
    pulse_start();
    hold_first = 1'b1;
    iter = 0;
    while (done_cnt == 0 && iter < 5000) begin
      @(posedge clk); #1;
      win_ready_d = 1'b0;
      start = 1'b0;
      iter++;
      if (iter == 30) begin
        chk("b_busy_mid", busy, 1);
        start = 1'b1;
      end
      if (bus.win_valid) begin
        if (hold_first) begin
          hold_first = 1'b0;
          start = 1'b0;
          wx0 = exp_wx.size() > 0 ? AW'(exp_wx[0]) : '1;
          wy0 = exp_wy.size() > 0 ? AW'(exp_wy[0]) : '1;
          repeat (5) begin
            chk("hold_valid", bus.win_valid, 1);
            chk("hold_x", bus.win_x, wx0);
            chk("hold_y", bus.win_y, wy0);
            chk("hold_rd_req", bus.rd_req, 0);
            chk("hold_strobe", {bus.gray_ready, bus.gray_ready2, bus.count, bus.num_pix_to_load}, 0);
            @(posedge clk); #1;
          end
          win_ready_d = 1'b1;
        end else if ($urandom_range(0, 2) == 0) begin
          win_ready_d = 1'b1;
        end
      end
    end
    win_ready_d = 1'b0;
    start = 1'b0;
    frame_checks("b");

    // Reset in WAIT, stray response afterwards, then a clean restart
    mon_en = 1'b0;
    mem_en = 1'b0;
    pulse_start();
    iter = 0;
    while (!bus.rd_req && iter < 50) begin
      @(posedge clk); #1;
      iter++;
    end
    chk("c_saw_req", bus.rd_req, 1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    stray_pix = 8'hAA;
    stray_valid = 1'b1;
    #1;
    chk("stray_gray_ready", bus.gray_ready, 0);
    chk("stray_gray_ready2", bus.gray_ready2, 0);
    chk("stray_count", bus.count, 0);
    chk("stray_num", bus.num_pix_to_load, 0);
    chk("stray_busy", busy, 0);
    @(posedge clk); #1;
    stray_valid = 1'b0;
    chk("post_rst_rd_req", bus.rd_req, 0);
    chk("post_rst_busy", busy, 0);

    mem_en = 1'b1;
    new_frame(1'b1);
    mon_en = 1'b1;
    win_ready_d = 1'b1;
    pulse_start();
    wait_done(3000);
    chk("c_first_addr", first_addr, 0);
    frame_checks("c");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
